seven_seg_mux: RTL and testbench
================================

# seven_seg_mux

Parametrised, time-multiplexed driver for an N-digit common-anode/common-cathode seven-segment display with decimal points. It adds four things to the earlier fixed 4-digit driver: an internal refresh prescaler, tear-free frame-synchronous value loading, leading-zero blanking and PWM brightness. It sits between any hex-valued status/debug source and the board display pins.

## Interface
- DIGITS, 4: number of digits, 1..8.
- REFRESH_DIV, 4000: CLK cycles per digit slot, ≥4 (4000 gives 1 kHz per slot at 4 MHz).
- ANODE_ACTIVE_LOW, 1: 1 means an active anode is driven 0.
- SEG_ACTIVE_LOW, 1: 1 means a lit segment or dp is driven 0.

- CLK  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- values  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, digit 0 rightmost.
- dp  in  DIGITS  decimal point per digit, 1 = lit.
- load  in  1  single-cycle strobe that samples values/dp.
- blank_lz  in  1  enable leading-zero blanking.
- brightness  in  4  duty in 16ths; 0 = dark, 15 = 15/16.
- cathodes  out  7  segments, bit6=a … bit0=g.
- dp_out  out  1  decimal point segment.
- anodes  out  DIGITS  one-hot digit enable.
- frame  out  1  one-cycle pulse at the end of each full scan.

## Operation
- Reset values: div_cnt=0, digit index=0, pwm_cnt=0, pending/display registers=0, pending_valid=0, frame=0. All anodes and all segments, including dp_out, are driven to their inactive level.
- Prescaler div_cnt counts 0..REFRESH_DIV-1. On its wrap the digit index advances; the index wraps from DIGITS-1 to 0.
- frame=1 for exactly the cycle in which div_cnt wraps while digit index = DIGITS-1.
- Loading:
  - load=1 copies values/dp into the pending registers and sets pending_valid.
  - On a frame cycle with pending_valid=1, pending is copied to the display registers and pending_valid is cleared.
  - load and frame in the same cycle: the incoming values/dp go straight to the display registers and pending_valid stays 0.
  - A second load before the next frame overwrites pending; the last load wins.
- Leading-zero blanking: digit i>0 is blanked when blank_lz=1 and display nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked. A blanked digit has all 7 segments off, but its dp still follows the dp bit.
- Decode, shown active-low with SEG_ACTIVE_LOW=1:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0001100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
  - With SEG_ACTIVE_LOW=0 every bit is inverted.
- Anode gating: the selected anode is active only when both of these hold:
  - pwm_cnt < brightness, where pwm_cnt is a free-running 4-bit counter incremented every CLK;
  - div_cnt ≠ 0, which gives a one-cycle ghosting guard at each slot start.
  - Otherwise all anodes are inactive.
- Segments and dp_out are driven for the selected digit regardless of PWM state.

## Timing
- All outputs are registered and reflect the counter state of the previous cycle: 1-cycle latency.
- After rst_n deasserts, the first active anode appears no earlier than cycle 2, since div_cnt=0 is guarded.
- Frame period = DIGITS*REFRESH_DIV cycles. The value applied at a frame cycle first appears on digit 0 outputs 1 cycle after the frame pulse.
- rst_n asserted mid-scan immediately, asynchronously, forces all outputs inactive and clears pending; no partial load survives.
- brightness is sampled every cycle with no synchronisation; a change takes effect on the next compare.

## Test plan
- Reset with DIGITS=4, REFRESH_DIV=8, brightness=15: all anodes 1111, cathodes 1111111 and dp_out 1 during reset; the first anode 1110 appears at cycle 2; digits scan 0→1→2→3 every 8 cycles; frame pulses every 32 cycles.
- load with values=16'h12AF mid-frame: cathodes keep showing 0000 until the next frame. Afterwards digit0=0111000 (F), digit1=0001000 (A), digit2=0010010 (2), digit3=1001111 (1).
- blank_lz=1, values=16'h0050, dp=4'b1000: digits 3 and 2 show segments 1111111 with dp_out=0 on digit 3. Digit 1 shows 5 and digit 0 shows 0. With values=16'h0000, only digit 0 shows 0000001.
- brightness=4: within each slot the anode is active exactly when pwm_cnt∈{0..3} and div_cnt≠0. brightness=0: anodes are never active.
- load coincident with frame, with a second load one cycle later: the first values display at once, the second are applied at the following frame. Asserting rst_n=0 between the two leaves the display at 0 after release.

Source files
------------

// File: rtl/seven_seg_mux_if.sv
// rtl/seven_seg_mux_if.sv - display driver signal bundle
// Ports (master = value source, slave = display driver):
//   values     4*DIGITS  hex nibbles, nibble i drives digit i (digit 0 rightmost)
//   dp         DIGITS    decimal point per digit, 1 = lit
//   load       1         single-cycle strobe sampling values/dp
//   blank_lz   1         leading-zero blanking enable
//   brightness 4         duty in 16ths
//   cathodes   7         segments, bit6=a .. bit0=g
//   dp_out     1         decimal point segment
//   anodes     DIGITS    one-hot digit enable
//   frame      1         one-cycle pulse at the end of each full scan
interface seven_seg_mux_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] values;
    logic [DIGITS-1:0]   dp;
    logic                load;
    logic                blank_lz;
    logic [3:0]          brightness;
    logic [6:0]          cathodes;
    logic                dp_out;
    logic [DIGITS-1:0]   anodes;
    logic                frame;

    modport master (
        output values, dp, load, blank_lz, brightness,
        input  cathodes, dp_out, anodes, frame
    );

    modport slave (
        input  values, dp, load, blank_lz, brightness,
        output cathodes, dp_out, anodes, frame
    );
endinterface

// File: rtl/seven_seg_mux.sv
// rtl/seven_seg_mux.sv - time-multiplexed N-digit seven-segment driver
// Ports:
//   CLK    system clock
//   rst_n  asynchronous active-low reset
//   bus    seven_seg_mux_if slave: values/dp/load/blank_lz/brightness in,
//          cathodes/dp_out/anodes/frame out (all outputs registered)
module seven_seg_mux #(
    parameter int DIGITS           = 4,
    parameter int REFRESH_DIV      = 4000,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 1
) (
    input  logic            CLK,
    input  logic            rst_n,
    seven_seg_mux_if.slave  bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [DIV_W-1:0]  LAST_DIV = DIV_W'(REFRESH_DIV - 1);
    // XOR masks that convert "lit/active = 1" into pin polarity; also the idle levels.
    localparam logic [6:0]        SEG_OFF  = {7{SEG_ACTIVE_LOW != 0}};
    localparam logic              DP_OFF   = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{ANODE_ACTIVE_LOW != 0}};

    logic [DIV_W-1:0]    div_cnt;
    logic [IDX_W-1:0]    idx;
    logic [3:0]          pwm_cnt;
    logic [4*DIGITS-1:0] pend_values;
    logic [DIGITS-1:0]   pend_dp;
    logic                pend_valid;
    logic [4*DIGITS-1:0] disp_values;
    logic [DIGITS-1:0]   disp_dp;

    logic [6:0]          cathodes_q;
    logic                dp_q;
    logic [DIGITS-1:0]   anodes_q;
    logic                frame_q;

    logic                div_wrap;
    logic                frame_cycle;
    logic [3:0]          nibble;
    logic                dp_sel;
    logic                lz_run;
    logic                lz_blank;
    logic [DIGITS-1:0]   onehot;
    logic [6:0]          seg_low;
    logic [6:0]          seg_lit;
    logic                anode_on;

    assign div_wrap    = (div_cnt == LAST_DIV);
    assign frame_cycle = div_wrap && (idx == LAST_IDX);

    // Walk from the leftmost digit down so lz_run means "this nibble and every
    // nibble to its left are zero" when the selected digit is reached.
    always_comb begin
        nibble   = 4'h0;
        dp_sel   = 1'b0;
        lz_run   = 1'b1;
        lz_blank = 1'b0;
        onehot   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lz_run = lz_run && (disp_values[4*i +: 4] == 4'h0);
            if (IDX_W'(i) == idx) begin
                nibble    = disp_values[4*i +: 4];
                dp_sel    = disp_dp[i];
                lz_blank  = lz_run && (i != 0);
                onehot[i] = 1'b1;
            end
        end
    end

    // Table held in active-low form, a..g from bit 6 down to bit 0.
    always_comb begin
        seg_low = 7'b1111111;
        case (nibble)
            4'h0: seg_low = 7'b0000001;
            4'h1: seg_low = 7'b1001111;
            4'h2: seg_low = 7'b0010010;
            4'h3: seg_low = 7'b0000110;
            4'h4: seg_low = 7'b1001100;
            4'h5: seg_low = 7'b0100100;
            4'h6: seg_low = 7'b0100000;
            4'h7: seg_low = 7'b0001111;
            4'h8: seg_low = 7'b0000000;
            4'h9: seg_low = 7'b0001100;
            4'hA: seg_low = 7'b0001000;
            4'hB: seg_low = 7'b1100000;
            4'hC: seg_low = 7'b0110001;
            4'hD: seg_low = 7'b1000010;
            4'hE: seg_low = 7'b0110000;
            default: seg_low = 7'b0111000;
        endcase
    end

    assign seg_lit  = (bus.blank_lz && lz_blank) ? 7'b0000000 : ~seg_low;
    // div_cnt == 0 keeps every anode off for one cycle at the slot change,
    // so the previous digit's segments never flash on the new anode.
    assign anode_on = (pwm_cnt < bus.brightness) && (div_cnt != '0);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            idx         <= '0;
            pwm_cnt     <= 4'h0;
            pend_values <= '0;
            pend_dp     <= '0;
            pend_valid  <= 1'b0;
            disp_values <= '0;
            disp_dp     <= '0;
            cathodes_q  <= SEG_OFF;
            dp_q        <= DP_OFF;
            anodes_q    <= AN_OFF;
            frame_q     <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'h1;
            if (div_wrap) begin
                div_cnt <= '0;
                idx     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            // Display registers only change at a frame boundary so a scan never
            // mixes old and new digits; a load landing on that boundary wins.
            if (frame_cycle && bus.load) begin
                disp_values <= bus.values;
                disp_dp     <= bus.dp;
                pend_valid  <= 1'b0;
            end else if (frame_cycle && pend_valid) begin
                disp_values <= pend_values;
                disp_dp     <= pend_dp;
                pend_valid  <= 1'b0;
            end else if (bus.load) begin
                pend_values <= bus.values;
                pend_dp     <= bus.dp;
                pend_valid  <= 1'b1;
            end

            cathodes_q <= seg_lit ^ SEG_OFF;
            dp_q       <= dp_sel ^ DP_OFF;
            anodes_q   <= (anode_on ? onehot : '0) ^ AN_OFF;
            frame_q    <= frame_cycle;
        end
    end

    assign bus.cathodes = cathodes_q;
    assign bus.dp_out   = dp_q;
    assign bus.anodes   = anodes_q;
    assign bus.frame    = frame_q;
endmodule

// File: tb/tb_seven_seg_mux.sv
// tb/tb_seven_seg_mux.sv - scoreboard bench for seven_seg_mux (4 digits, 8-cycle slots)
module tb_seven_seg_mux;
    logic CLK = 1'b0;
    logic rst_n;
    always #5 CLK = ~CLK;

    seven_seg_mux_if #(.DIGITS(4)) bus ();

    seven_seg_mux #(
        .DIGITS(4),
        .REFRESH_DIV(8),
        .ANODE_ACTIVE_LOW(1),
        .SEG_ACTIVE_LOW(1)
    ) dut (
        .CLK(CLK),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int         cyc;
        logic [6:0] cat;
        logic       dpo;
        logic [3:0] an;
        logic       fr;
    } exp_t;

    exp_t  q[$];
    string qn[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc;

    // Cycle k = interval after the k-th rising edge since reset release.
    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    exp_t  me;
    string mn;
    always @(negedge CLK) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            me = q.pop_front();
            mn = qn.pop_front();
            total++;
            if (me.cyc < cyc) begin
                bad++;
                $display("FAIL %s: check for cycle %0d reached late at cycle %0d", mn, me.cyc, cyc);
            end else if (bus.cathodes !== me.cat || bus.dp_out !== me.dpo ||
                         bus.anodes !== me.an || bus.frame !== me.fr) begin
                bad++;
                $display("FAIL %s cyc=%0d: got cat=%b dp=%b an=%b fr=%b, want cat=%b dp=%b an=%b fr=%b",
                         mn, cyc, bus.cathodes, bus.dp_out, bus.anodes, bus.frame,
                         me.cat, me.dpo, me.an, me.fr);
            end
        end
    end

    task automatic push_idle(input string name);
        exp_t e;
        e.cyc = 0; e.cat = 7'b1111111; e.dpo = 1'b1; e.an = 4'b1111; e.fr = 1'b0;
        q.push_back(e);
        qn.push_back(name);
    endtask

    // Output seen in frame f, digit slot d, offset off reflects counter state one cycle earlier.
    task automatic push_slot(input string name, input int f, input int d, input int off,
                             input logic [6:0] cat, input logic dpo, input int br);
        exp_t e;
        logic [3:0] oh;
        int k;
        k  = 32*f + 8*d + 1 + off;
        oh = 4'b0001 << d;
        e.cyc = k;
        e.cat = cat;
        e.dpo = dpo;
        e.an  = (off != 0 && ((k - 1) % 16) < br) ? ~oh : 4'b1111;
        e.fr  = (k % 32 == 0);
        q.push_back(e);
        qn.push_back(name);
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic do_load(input int k, input logic [15:0] v, input logic [3:0] d);
        wait_cyc(k);
        bus.values = v;
        bus.dp     = d;
        bus.load   = 1'b1;
        wait_cyc(k + 1);
        bus.load   = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.values     = 16'h0;
        bus.dp         = 4'h0;
        bus.load       = 1'b0;
        bus.blank_lz   = 1'b0;
        bus.brightness = 4'd15;

        push_idle("reset_idle");
        push_slot("first_guard", 0, 0, 0, 7'b0000001, 1'b1, 15);
        push_slot("first_anode", 0, 0, 1, 7'b0000001, 1'b1, 15);
        push_slot("scan_d1",     0, 1, 3, 7'b0000001, 1'b1, 15);
        push_slot("scan_d2",     0, 2, 5, 7'b0000001, 1'b1, 15);
        push_slot("scan_d3",     0, 3, 2, 7'b0000001, 1'b1, 15);
        push_slot("frame0",      0, 3, 7, 7'b0000001, 1'b1, 15);
        push_slot("no_frame",    1, 0, 0, 7'b0000001, 1'b1, 15);
        repeat (3) @(posedge CLK);
        #2 rst_n = 1'b1;

        // Mid-frame load stays pending until the frame boundary.
        push_slot("hold_old", 1, 2, 4, 7'b0000001, 1'b1, 15);
        push_slot("dig0_F",   2, 0, 2, 7'b0111000, 1'b1, 15);
        push_slot("dig1_A",   2, 1, 3, 7'b0001000, 1'b1, 15);
        push_slot("dig2_2",   2, 2, 4, 7'b0010010, 1'b1, 15);
        push_slot("dig3_1",   2, 3, 5, 7'b1001111, 1'b1, 15);
        do_load(40, 16'h12AF, 4'b0000);

        // Leading-zero blanking.
        push_slot("lz_d0",    4, 0, 1, 7'b0000001, 1'b1, 15);
        push_slot("lz_d1",    4, 1, 1, 7'b0100100, 1'b1, 15);
        push_slot("lz_d2",    4, 2, 1, 7'b1111111, 1'b1, 15);
        push_slot("lz_d3_dp", 4, 3, 1, 7'b1111111, 1'b0, 15);
        wait_cyc(100);
        bus.blank_lz = 1'b1;
        do_load(100, 16'h0050, 4'b1000);

        push_slot("zero_d0", 5, 0, 4, 7'b0000001, 1'b1, 15);
        push_slot("zero_d1", 5, 1, 4, 7'b1111111, 1'b1, 15);
        push_slot("zero_d3", 5, 3, 4, 7'b1111111, 1'b1, 15);
        do_load(140, 16'h0000, 4'b0000);

        // PWM duty.
        wait_cyc(190);
        bus.brightness = 4'd4;
        for (int o = 0; o < 8; o++)
            push_slot("pwm4_d0", 6, 0, o, 7'b0000001, 1'b1, 4);
        push_slot("pwm4_d2", 6, 2, 1, 7'b1111111, 1'b1, 4);
        wait_cyc(215);
        bus.brightness = 4'd0;
        for (int o = 0; o < 8; o++)
            push_slot("dark_d1", 7, 1, o, 7'b1111111, 1'b1, 0);
        wait_cyc(260);
        bus.brightness = 4'd15;

        // Load on the frame cycle, then another load one cycle later.
        push_slot("frame_pulse", 9, 3, 7, 7'b1111111, 1'b1, 15);
        push_slot("coin_d0",  10, 0, 2, 7'b0100000, 1'b1, 15);
        push_slot("coin_d1",  10, 1, 2, 7'b0100100, 1'b1, 15);
        push_slot("coin_d2",  10, 2, 2, 7'b1001100, 1'b1, 15);
        push_slot("coin_d3",  10, 3, 2, 7'b0000110, 1'b1, 15);
        push_slot("next_d0",  11, 0, 2, 7'b0110001, 1'b1, 15);
        push_slot("next_d1",  11, 1, 2, 7'b0001100, 1'b1, 15);
        push_slot("next_d2",  11, 2, 2, 7'b0000000, 1'b1, 15);
        push_slot("next_d3",  11, 3, 2, 7'b0001111, 1'b1, 15);
        wait_cyc(319);
        bus.values = 16'h3456;
        bus.dp     = 4'b0000;
        bus.load   = 1'b1;
        wait_cyc(320);
        bus.values = 16'h789C;
        wait_cyc(321);
        bus.load   = 1'b0;

        // Pending load discarded by a mid-scan asynchronous reset.
        do_load(400, 16'hDEAD, 4'b1111);
        wait_cyc(405);
        #1;
        rst_n = 1'b0;
        push_idle("async_rst");
        push_slot("post_first", 0, 0, 1, 7'b0000001, 1'b1, 15);
        push_slot("post_d0",    1, 0, 3, 7'b0000001, 1'b1, 15);
        push_slot("post_d1",    1, 1, 3, 7'b1111111, 1'b1, 15);
        push_slot("post_d3",    1, 3, 3, 7'b1111111, 1'b1, 15);
        repeat (2) @(posedge CLK);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 300 && q.size() > 0; i++) @(posedge CLK);
        if (q.size() > 0) begin
            $display("FAIL drain: %0d checks still pending, want 0", q.size());
            bad++;
        end
        @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
